// File: rtl/i2c_eeprom_slave.sv
// i2c_eeprom_slave: I2C responder modelling a 2-byte-addressed EEPROM (24C64 style) over a synchronous RAM port
//   clk, rst_n            system clock, asynchronous active-low reset
//   i2c_scl, i2c_sda      bus clock from master, open-drain data (drives 0 or z only)
//   mem_addr, mem_wr_en   registered RAM address, one-cycle write strobe
//   mem_wr_data           write byte
//   mem_rd_data           read byte, valid 1 clk after mem_addr changes
//   busy                  transaction addressed to this device in progress
module i2c_eeprom_slave #(
  parameter logic [6:0] DEVICE_ADDR = 7'b1010_011,
  parameter int         ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i2c_scl,
  inout  wire               i2c_sda,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_en,
  output logic [7:0]        mem_wr_data,
  input  logic [7:0]        mem_rd_data,
  output logic              busy
);
  typedef enum logic [3:0] {
    IDLE, DEV, DEV_ACK, AH, AH_ACK, AL, AL_ACK, WDATA, WDATA_ACK, RDATA, MACK, WAIT_STOP
  } state_t;
  state_t state_q, state_d;
  logic [2:0] scl_q, scl_d, sda_q, sda_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d, tx_q, tx_d, wr_data_q, wr_data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic wr_en_q, wr_en_d, oe_q, oe_d, busy_q, busy_d;
  logic scl_rise, scl_fall, start, stop, sda_in, rx_st, ack_st, byte_done, ack_end, dev_hit;
  logic [7:0] byte_in;
  // [0] first sync stage, [1] synchronized value, [2] previous synchronized value
  assign scl_d     = {scl_q[1:0], i2c_scl};
  assign sda_d     = {sda_q[1:0], i2c_sda};
  assign sda_in    = sda_q[1];
  assign scl_rise  = scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] & scl_q[2];
  assign start     = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
  assign stop      = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
  assign rx_st     = state_q inside {DEV, AH, AL, WDATA};
  assign ack_st    = state_q inside {DEV_ACK, AH_ACK, AL_ACK, WDATA_ACK};
  assign byte_in   = {shift_q[6:0], sda_in};
  assign byte_done = rx_st & scl_rise & (bit_cnt_q == 3'd7);
  // oe_q doubles as the ACK phase marker: set on the fall after bit 8, cleared on the next fall
  assign ack_end   = ack_st & scl_fall & oe_q;
  assign dev_hit   = byte_in[7:1] == DEVICE_ADDR;
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    addr_d    = wr_en_q ? addr_q + ADDR_W'(1) : addr_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    oe_d      = oe_q;
    busy_d    = busy_q;
    if (stop) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      oe_d    = 1'b0;
    end else if (start) begin
      state_d   = DEV;
      busy_d    = 1'b1;
      oe_d      = 1'b0;
      bit_cnt_d = 3'd0;
    end else begin
      if (rx_st && scl_rise) begin
        shift_d   = byte_in;
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      if (ack_st && scl_fall) oe_d = ~oe_q;
      case (state_q)
        DEV: if (byte_done) begin
          state_d = dev_hit ? DEV_ACK : WAIT_STOP;
          busy_d  = dev_hit;
        end
        AH: if (byte_done) begin
          addr_d[ADDR_W-1:8] = byte_in[ADDR_W-9:0];
          state_d            = AH_ACK;
        end
        AL: if (byte_done) begin
          addr_d[7:0] = byte_in;
          state_d     = AL_ACK;
        end
        WDATA: if (byte_done) begin
          wr_en_d   = 1'b1;
          wr_data_d = byte_in;
          state_d   = WDATA_ACK;
        end
        // shift_q still holds the device byte; its LSB selects read or write
        DEV_ACK: if (ack_end) begin
          state_d = shift_q[0] ? RDATA : AH;
          tx_d    = mem_rd_data;
          oe_d    = shift_q[0] & ~mem_rd_data[7];
        end
        AH_ACK: if (ack_end) state_d = AL;
        AL_ACK, WDATA_ACK: if (ack_end) state_d = WDATA;
        RDATA: if (scl_fall) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          tx_d      = {tx_q[6:0], 1'b0};
          oe_d      = (bit_cnt_q != 3'd7) & ~tx_q[6];
          state_d   = bit_cnt_q == 3'd7 ? MACK : RDATA;
        end
        MACK: if (scl_rise) begin
          state_d = sda_in ? WAIT_STOP : MACK;
          addr_d  = sda_in ? addr_q : addr_q + ADDR_W'(1);
        end else if (scl_fall) begin
          state_d = RDATA;
          tx_d    = mem_rd_data;
          oe_d    = ~mem_rd_data[7];
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      scl_q     <= 3'b111;
      sda_q     <= 3'b111;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'd0;
      tx_q      <= 8'd0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= 8'd0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      scl_q     <= scl_d;
      sda_q     <= sda_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
    end
  end
  assign i2c_sda     = oe_q ? 1'b0 : 1'bz;
  assign mem_addr    = addr_q;
  assign mem_wr_en   = wr_en_q;
  assign mem_wr_data = wr_data_q;
  assign busy        = busy_q;
endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// tb_i2c_eeprom_slave: vector table, randomized transactions and corner sequences against a transaction-level EEPROM model
module tb_i2c_eeprom_slave;
  logic clk = 1'b0, rst_n = 1'b0, scl = 1'b1, m_drv = 1'b0;
  wire sda;
  logic [15:0] mem_addr;
  logic mem_wr_en, busy;
  logic [7:0] mem_wr_data, mem_rd_data;
  assign sda = m_drv ? 1'b0 : 1'bz;
  pullup (sda);
  i2c_eeprom_slave dut (
    .clk(clk), .rst_n(rst_n), .i2c_scl(scl), .i2c_sda(sda),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data), .busy(busy)
  );
  always #10 clk = ~clk;
  logic [7:0] mem [0:65535];
  logic [7:0] ref_mem [0:65535];
  logic [15:0] ref_ptr;
  typedef struct { logic [15:0] a; logic [7:0] d; } wr_t;
  wr_t wr_log[$];
  always @(posedge clk) mem_rd_data <= mem[mem_addr];
  always @(negedge clk) if (rst_n && mem_wr_en) begin
    mem[mem_addr] = mem_wr_data;
    wr_log.push_back('{mem_addr, mem_wr_data});
  end
  int checks = 0, failures = 0;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic put_bit(input logic b, output logic s);
    m_drv = ~b;
    wclk(5); scl = 1'b1;
    wclk(5); s = sda;
    wclk(5); scl = 1'b0;
    wclk(5);
  endtask
  task automatic i2c_start;
    m_drv = 1'b0; wclk(5);
    scl = 1'b1; wclk(5);
    m_drv = 1'b1; wclk(5);
    scl = 1'b0; wclk(5);
  endtask
  task automatic i2c_stop;
    m_drv = 1'b1; wclk(5);
    scl = 1'b1; wclk(5);
    m_drv = 1'b0; wclk(10);
  endtask
  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) put_bit(b[i], s);
    put_bit(1'b1, s);
    ack = ~s;
  endtask
  task automatic recv_byte(output logic [7:0] b, input logic mack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      put_bit(1'b1, s);
      b[i] = s;
    end
    put_bit(~mack, s);
  endtask
  task automatic tx_write(input logic [15:0] a, input int n, input logic [7:0] d0, output int acks);
    logic ack;
    logic [15:0] ai;
    logic [7:0] b;
    wr_log.delete();
    acks = 0;
    i2c_start;
    send_byte(8'hA6, ack); acks += int'(ack);
    send_byte(a[15:8], ack); acks += int'(ack);
    send_byte(a[7:0], ack); acks += int'(ack);
    for (int i = 0; i < n; i++) begin
      b  = d0 + 8'(i * 17);
      ai = a + 16'(i);
      send_byte(b, ack); acks += int'(ack);
      ref_mem[ai] = b;
    end
    chk("busy_active", int'(busy), 1);
    i2c_stop;
    chk("busy_after_stop", int'(busy), 0);
    chk("wr_count", wr_log.size(), n);
    for (int i = 0; i < wr_log.size() && i < n; i++) begin
      ai = a + 16'(i);
      b  = d0 + 8'(i * 17);
      chk("wr_addr", int'(wr_log[i].a), int'(ai));
      chk("wr_data", int'(wr_log[i].d), int'(b));
    end
    ref_ptr = a + 16'(n);
  endtask
  task automatic tx_read(input bit rnd, input logic [15:0] a, input int n, output int acks, output int first);
    logic ack;
    logic [7:0] b;
    wr_log.delete();
    acks  = 0;
    first = -1;
    if (rnd) begin
      i2c_start;
      send_byte(8'hA6, ack); acks += int'(ack);
      send_byte(a[15:8], ack); acks += int'(ack);
      send_byte(a[7:0], ack); acks += int'(ack);
      ref_ptr = a;
    end
    i2c_start;
    send_byte(8'hA7, ack); acks += int'(ack);
    for (int i = 0; i < n; i++) begin
      recv_byte(b, i < n - 1);
      if (i == 0) first = int'(b);
      chk("rd_data", int'(b), int'(ref_mem[ref_ptr]));
      if (i < n - 1) ref_ptr = ref_ptr + 16'd1;
    end
    wclk(2);
    chk("sda_released_after_nack", int'(sda), 1);
    i2c_stop;
    chk("busy_after_stop", int'(busy), 0);
    chk("rd_no_write", wr_log.size(), 0);
  endtask
  typedef struct {
    int          op;
    logic [15:0] a;
    int          n;
    logic [7:0]  d0;
    int          exp_acks;
    int          exp_first;
    logic [15:0] exp_end;
  } vec_t;
  vec_t vecs[8];
  initial begin
    int acks, first, op, n;
    logic ack, s;
    logic [7:0] v;
    logic [15:0] a;
    vecs[0] = '{0, 16'h0012, 1, 8'h5A, 4, -1,     16'h0013};
    vecs[1] = '{1, 16'h0012, 1, 8'h00, 4, 'h5A,   16'h0012};
    vecs[2] = '{0, 16'hFFFF, 2, 8'h77, 5, -1,     16'h0001};
    vecs[3] = '{1, 16'hFFFF, 3, 8'h00, 4, 'h77,   16'h0001};
    vecs[4] = '{0, 16'h0020, 3, 8'h11, 6, -1,     16'h0023};
    vecs[5] = '{1, 16'h0020, 3, 8'h00, 4, 'h11,   16'h0022};
    vecs[6] = '{2, 16'h0000, 1, 8'h00, 1, 'h33,   16'h0022};
    vecs[7] = '{2, 16'h0000, 2, 8'h00, 1, 'h33,   16'h0023};
    for (int i = 0; i < 65536; i++) begin
      v = 8'($urandom);
      mem[i] = v;
      ref_mem[i] = v;
    end
    ref_ptr = 16'h0000;
    wclk(3);
    chk("rst_sda", int'(sda), 1);
    chk("rst_addr", int'(mem_addr), 0);
    chk("rst_wr_en", int'(mem_wr_en), 0);
    chk("rst_wr_data", int'(mem_wr_data), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    wclk(3);
    foreach (vecs[i]) begin
      if (vecs[i].op == 0) tx_write(vecs[i].a, vecs[i].n, vecs[i].d0, acks);
      else tx_read(vecs[i].op == 1, vecs[i].a, vecs[i].n, acks, first);
      chk("vec_acks", acks, vecs[i].exp_acks);
      if (vecs[i].exp_first >= 0) chk("vec_first", first, vecs[i].exp_first);
      chk("vec_end_addr", int'(mem_addr), int'(vecs[i].exp_end));
    end
    for (int t = 0; t < 16; t++) begin
      op = int'($urandom_range(0, 2));
      n  = int'($urandom_range(1, 4));
      a  = ($urandom_range(0, 3) == 0) ? 16'hFFFD + 16'($urandom_range(0, 2)) : 16'($urandom);
      if (op == 0) begin
        tx_write(a, n, 8'($urandom), acks);
        chk("rnd_wr_acks", acks, 3 + n);
      end else begin
        tx_read(op == 1, a, n, acks, first);
        chk("rnd_rd_acks", acks, op == 1 ? 4 : 1);
      end
      chk("rnd_ptr", int'(mem_addr), int'(ref_ptr));
    end
    wr_log.delete();
    i2c_start;
    send_byte(8'hA4, ack);
    chk("wrong_addr_nack", int'(ack), 0);
    wclk(2);
    chk("wrong_addr_busy", int'(busy), 0);
    i2c_start;
    send_byte(8'hA6, ack);
    chk("after_wrong_ack", int'(ack), 1);
    chk("after_wrong_busy", int'(busy), 1);
    i2c_stop;
    chk("wrong_addr_no_write", wr_log.size(), 0);
    chk("wrong_addr_ptr", int'(mem_addr), int'(ref_ptr));
    i2c_start;
    send_byte(8'hA6, ack);
    send_byte(8'h01, ack);
    send_byte(8'h00, ack);
    for (int i = 0; i < 5; i++) put_bit(1'b0, s);
    i2c_stop;
    ref_ptr = 16'h0100;
    chk("abort_no_write", wr_log.size(), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_ptr", int'(mem_addr), int'(ref_ptr));
    tx_write(16'h0200, 1, 8'h00, acks);
    i2c_start;
    send_byte(8'hA6, ack);
    send_byte(8'h02, ack);
    send_byte(8'h00, ack);
    i2c_start;
    send_byte(8'hA7, ack);
    chk("msb_driven_low", int'(sda), 0);
    rst_n = 1'b0;
    #1;
    chk("midrd_rst_sda", int'(sda), 1);
    chk("midrd_rst_addr", int'(mem_addr), 0);
    chk("midrd_rst_busy", int'(busy), 0);
    chk("midrd_rst_wr_en", int'(mem_wr_en), 0);
    chk("midrd_rst_wr_data", int'(mem_wr_data), 0);
    scl = 1'b1;
    wclk(5);
    rst_n = 1'b1;
    ref_ptr = 16'h0000;
    wclk(5);
    tx_read(1'b0, 16'h0000, 1, acks, first);
    chk("post_rst_acks", acks, 1);
    chk("post_rst_ptr", int'(mem_addr), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
